// File: rtl/imm_encoder_pkg.sv
// Shared types, field geometry and range helper for the LEGv8 immediate encoder.
package legv8_imm_pkg;

   localparam int unsigned N       = 64;
   localparam int unsigned CNT_W   = 32;
   localparam int unsigned INSTR_W = 32;

   localparam int unsigned IMM_D_W    = 9;
   localparam int unsigned IMM_D_LSB  = 12;
   localparam int unsigned IMM_CB_W   = 19;
   localparam int unsigned IMM_CB_LSB = 5;
   localparam int unsigned IMM_B_W    = 26;
   localparam int unsigned IMM_B_LSB  = 0;

   typedef enum logic [1:0] {
      FMT_D   = 2'b00,
      FMT_CB  = 2'b01,
      FMT_B   = 2'b10,
      FMT_ILL = 2'b11
   } imm_fmt_t;

   typedef struct packed {
      imm_fmt_t           fmt;
      logic [INSTR_W-1:0] base;
      logic [N-1:0]       imm;
   } imm_req_t;

   // True when imm[N-1:w-1] are all equal, i.e. imm survives truncation to w bits.
   function automatic logic fits_signed(input logic [N-1:0] imm, input int unsigned w);
      logic [N-1:0] hi;
      hi = N'($signed(imm) >>> (w - 1));
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Input/output handshake bundle and statistics of the immediate encoder.
interface imm_encoder_if;
   import legv8_imm_pkg::*;

   logic               in_valid;
   logic               in_ready;
   imm_fmt_t           fmt;
   logic [INSTR_W-1:0] base_instr;
   logic [N-1:0]       imm;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] instr_out;
   logic               range_err;
   logic [CNT_W-1:0]   enc_count;
   logic [CNT_W-1:0]   err_count;

   modport slave (
      input  in_valid, fmt, base_instr, imm, out_ready,
      output in_ready, out_valid, instr_out, range_err, enc_count, err_count
   );

   modport master (
      output in_valid, fmt, base_instr, imm, out_ready,
      input  in_ready, out_valid, instr_out, range_err, enc_count, err_count
   );
endinterface

// File: rtl/imm_encoder_pack.sv
// Combinational field packer: overwrites the format's immediate field and flags overflow.
module imm_field_pack
   import legv8_imm_pkg::*;
(
   input  imm_req_t           req_i,
   output logic [INSTR_W-1:0] instr_c_o,
   output logic               range_err_c_o
);

   always_comb begin
      instr_c_o     = req_i.base;
      range_err_c_o = 1'b0;
      case (req_i.fmt)
         FMT_D: begin
            instr_c_o[IMM_D_LSB +: IMM_D_W] = req_i.imm[IMM_D_W-1:0];
            range_err_c_o                   = !fits_signed(req_i.imm, IMM_D_W);
         end
         FMT_CB: begin
            instr_c_o[IMM_CB_LSB +: IMM_CB_W] = req_i.imm[IMM_CB_W-1:0];
            range_err_c_o                     = !fits_signed(req_i.imm, IMM_CB_W);
         end
         FMT_B: begin
            instr_c_o[IMM_B_LSB +: IMM_B_W] = req_i.imm[IMM_B_W-1:0];
            range_err_c_o                   = !fits_signed(req_i.imm, IMM_B_W);
         end
         default: range_err_c_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder with saturating output statistics.
module imm_encoder
   import legv8_imm_pkg::*;
(
   input logic          clk,
   input logic          reset,
   imm_encoder_if.slave bus
);

   logic               s1_valid_q, s1_valid_d;
   imm_req_t           s1_req_q,   s1_req_d;
   logic               s2_valid_q, s2_valid_d;
   logic [INSTR_W-1:0] instr_q,    instr_d;
   logic               err_q,      err_d;
   logic [CNT_W-1:0]   enc_q,      enc_d;
   logic [CNT_W-1:0]   errc_q,     errc_d;

   logic               s2_load;
   logic               in_acc;
   logic               out_hs;
   logic [INSTR_W-1:0] pack_instr;
   logic               pack_err;

   imm_field_pack u_pack (
      .req_i         (s1_req_q),
      .instr_c_o     (pack_instr),
      .range_err_c_o (pack_err)
   );

   // in_ready depends only on state and out_ready, never on in_valid.
   assign s2_load      = s1_valid_q && (!s2_valid_q || bus.out_ready);
   assign bus.in_ready = !s1_valid_q || s2_load;
   assign in_acc       = bus.in_valid && bus.in_ready;
   assign out_hs       = s2_valid_q && bus.out_ready;

   assign bus.out_valid = s2_valid_q;
   assign bus.instr_out = instr_q;
   assign bus.range_err = err_q;
   assign bus.enc_count = enc_q;
   assign bus.err_count = errc_q;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_req_d   = s1_req_q;
      s2_valid_d = s2_valid_q;
      instr_d    = instr_q;
      err_d      = err_q;
      enc_d      = enc_q;
      errc_d     = errc_q;

      if (in_acc) begin
         s1_valid_d    = 1'b1;
         s1_req_d.fmt  = bus.fmt;
         s1_req_d.base = bus.base_instr;
         s1_req_d.imm  = bus.imm;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end

      if (s2_load) begin
         s2_valid_d = 1'b1;
         instr_d    = pack_instr;
         err_d      = pack_err;
      end else if (out_hs) begin
         s2_valid_d = 1'b0;
      end

      // Counters see the departing word (err_q), even when S2 reloads in the same cycle.
      if (out_hs) begin
         if (enc_q != '1) enc_d = enc_q + CNT_W'(1);
         if (err_q && (errc_q != '1)) errc_d = errc_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_req_q   <= '0;
         s2_valid_q <= 1'b0;
         instr_q    <= '0;
         err_q      <= 1'b0;
         enc_q      <= '0;
         errc_q     <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_req_q   <= s1_req_d;
         s2_valid_q <= s2_valid_d;
         instr_q    <= instr_d;
         err_q      <= err_d;
         enc_q      <= enc_d;
         errc_q     <= errc_d;
      end
   end

endmodule
